// File: rtl/mmio_timer_responder_pkg.sv
// mmio_timer_responder_pkg: register offsets, bit indices, default base and byte-merge helper
package mmio_timer_responder_pkg;
   localparam logic [31:0] TMR_BASE_ADDR = 32'hFF20_0500;
   localparam logic [4:0] TMR_CTRL = 5'h00;
   localparam logic [4:0] TMR_COUNT = 5'h04;
   localparam logic [4:0] TMR_CMP = 5'h08;
   localparam logic [4:0] TMR_STATUS = 5'h0C;
   localparam logic [4:0] TMR_PRESC = 5'h10;
   localparam int CTRL_EN = 0;
   localparam int CTRL_AUTORELOAD = 1;
   localparam int CTRL_IRQEN = 2;
   localparam int STATUS_MATCH = 0;
   function automatic logic [31:0] be_merge(input logic [31:0] old_v, input logic [31:0] new_v, input logic [3:0] be);
      logic [31:0] r;
      for (int i = 0; i < 4; i++) r[8*i +: 8] = be[i] ? new_v[8*i +: 8] : old_v[8*i +: 8];
      return r;
   endfunction
endpackage

// File: rtl/timer_prescaler.sv
// timer_prescaler: reloadable 16-bit down-counter issuing one tick every value+1 enabled cycles
module timer_prescaler (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        en_i,
   input  logic        load_i,
   input  logic [15:0] value_i,
   output logic        tick_o
);
   logic [15:0] cnt_q, cnt_d;
   assign tick_o = en_i & (cnt_q == 16'd0);
   // reload on a write or after a tick, hold while disabled, otherwise count down
   always_comb cnt_d = load_i ? value_i : !en_i ? cnt_q : tick_o ? value_i : cnt_q - 16'd1;
   // down-counter register
   always_ff @(posedge clk_i) cnt_q <= rst_i ? 16'd0 : cnt_d;
endmodule

// File: rtl/mmio_timer_responder.sv
// mmio_timer_responder: bus-mapped free-running timer with compare match IRQ; optional TIMER_PRESCALER_EN
module mmio_timer_responder
   import mmio_timer_responder_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR = TMR_BASE_ADDR
) (
   input  logic        iCLK,
   input  logic        iRST,
   input  logic        iReadEnable,
   input  logic        iWriteEnable,
   input  logic [3:0]  iByteEnable,
   input  logic [31:0] iAddress,
   input  logic [31:0] iWriteData,
   output logic [31:0] oReadData,
   output logic        oHit,
   output logic        oIRQ
);
   logic [4:0]  off;
   logic        wr, count_wr, tick, cmp_eq, match_set, unused_addr;
   logic [2:0]  ctrl_q, ctrl_d;
   logic [31:0] count_q, count_d, cmp_q, cmp_d, rd, presc_rd;
   logic        match_q, match_d;
   assign unused_addr = ^iAddress[1:0];
   assign oHit = iAddress[31:5] == BASE_ADDR[31:5];
   assign off = {iAddress[4:2], 2'b00};
   assign wr = iWriteEnable & oHit;
   assign count_wr = wr & (off == TMR_COUNT) & (|iByteEnable);
   assign cmp_eq = count_q == cmp_q;
   assign match_set = tick & ~count_wr & cmp_eq;
   assign oIRQ = match_q & ctrl_q[CTRL_IRQEN];
`ifdef TIMER_PRESCALER_EN
   logic [15:0] presc_q, presc_d;
   logic        presc_wr;
   assign presc_wr = wr & (off == TMR_PRESC) & (|iByteEnable[1:0]);
   assign presc_d = presc_wr ? {iByteEnable[1] ? iWriteData[15:8] : presc_q[15:8],
                                iByteEnable[0] ? iWriteData[7:0] : presc_q[7:0]} : presc_q;
   assign presc_rd = {16'd0, presc_q};
   timer_prescaler u_presc (
      .clk_i  (iCLK),
      .rst_i  (iRST),
      .en_i   (ctrl_q[CTRL_EN]),
      .load_i (presc_wr),
      .value_i(presc_d),
      .tick_o (tick)
   );
   // prescaler reload value register
   always_ff @(posedge iCLK) presc_q <= iRST ? 16'd0 : presc_d;
`else
   assign tick = ctrl_q[CTRL_EN];
   assign presc_rd = 32'd0;
`endif
   // next state: CPU writes take priority over the tick on COUNT; a match set beats a W1C clear
   always_comb begin
      ctrl_d = (wr & (off == TMR_CTRL) & iByteEnable[0]) ? iWriteData[2:0] : ctrl_q;
      cmp_d = (wr & (off == TMR_CMP)) ? be_merge(cmp_q, iWriteData, iByteEnable) : cmp_q;
      count_d = count_wr ? be_merge(count_q, iWriteData, iByteEnable) :
                !tick ? count_q :
                (cmp_eq & ctrl_q[CTRL_AUTORELOAD]) ? 32'd0 : count_q + 32'd1;
      match_d = match_set | (match_q & ~(wr & (off == TMR_STATUS) & iByteEnable[0] & iWriteData[0]));
   end
   // register read mux, sampled combinationally by the datapath
   always_comb rd = (off == TMR_CTRL)   ? {29'd0, ctrl_q} :
                    (off == TMR_COUNT)  ? count_q :
                    (off == TMR_CMP)    ? cmp_q :
                    (off == TMR_STATUS) ? {31'd0, match_q} :
                    (off == TMR_PRESC)  ? presc_rd : 32'd0;
   assign oReadData = (oHit & iReadEnable) ? rd : 32'd0;
   // timer register file
   always_ff @(posedge iCLK) begin
      if (iRST) begin
         ctrl_q <= 3'd0;
         count_q <= 32'd0;
         cmp_q <= 32'd0;
         match_q <= 1'b0;
      end else begin
         ctrl_q <= ctrl_d;
         count_q <= count_d;
         cmp_q <= cmp_d;
         match_q <= match_d;
      end
   end
endmodule

// File: tb/tb_mmio_timer_responder.sv
// tb_mmio_timer_responder: directed and random checks of the timer against a behavioural model
module tb_mmio_timer_responder;
   localparam logic [31:0] BASE = 32'hFF20_0500;
   logic        clk, iRST, iReadEnable, iWriteEnable, oHit, oIRQ;
   logic [3:0]  iByteEnable;
   logic [31:0] iAddress, iWriteData, oReadData;
   int n_cmp = 0, n_bad = 0;
   logic [2:0]  m_ctrl;
   logic [31:0] m_count, m_cmp;
   logic        m_match;
   logic [15:0] m_presc;
   int          m_ecnt;
   logic [31:0] r;
   logic        q;

   mmio_timer_responder dut (
      .iCLK(clk), .iRST(iRST), .iReadEnable(iReadEnable), .iWriteEnable(iWriteEnable),
      .iByteEnable(iByteEnable), .iAddress(iAddress), .iWriteData(iWriteData),
      .oReadData(oReadData), .oHit(oHit), .oIRQ(oIRQ)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed 0x%h required 0x%h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] be);
      logic [31:0] x;
      x = o;
      for (int i = 0; i < 4; i++) if (be[i]) x[8*i +: 8] = n[8*i +: 8];
      return x;
   endfunction

   function automatic logic [31:0] m_read(input logic [31:0] a);
      if (a[31:5] != BASE[31:5]) return 32'd0;
      case (a[4:2])
         3'd0: return {29'd0, m_ctrl};
         3'd1: return m_count;
         3'd2: return m_cmp;
         3'd3: return {31'd0, m_match};
`ifdef TIMER_PRESCALER_EN
         3'd4: return {16'd0, m_presc};
`endif
         default: return 32'd0;
      endcase
   endfunction

   task automatic model_step(input logic rst, input logic we, input logic [3:0] be, input logic [31:0] a, input logic [31:0] wd);
      logic w, tick, cw, set;
      logic [4:0] o;
      logic [31:0] nc, t;
      if (rst) begin
         m_ctrl = 0; m_count = 0; m_cmp = 0; m_match = 0; m_presc = 0; m_ecnt = 0;
         return;
      end
      o = {a[4:2], 2'b00};
      w = we && (a[31:5] == BASE[31:5]);
`ifdef TIMER_PRESCALER_EN
      tick = m_ctrl[0] && (m_ecnt % (int'(m_presc) + 1) == 0);
`else
      tick = m_ctrl[0];
`endif
      cw = w && o == 5'h04 && be != 4'd0;
      nc = cw ? merge(m_count, wd, be) : m_count;
      set = 1'b0;
      if (!cw && tick) begin
         set = (m_count == m_cmp);
         nc = (set && m_ctrl[1]) ? 32'd0 : m_count + 32'd1;
      end
      if (w && o == 5'h08) m_cmp = merge(m_cmp, wd, be);
      if (w && o == 5'h0C && be[0] && wd[0]) m_match = 1'b0;
      if (set) m_match = 1'b1;
`ifdef TIMER_PRESCALER_EN
      if (w && o == 5'h10 && be[1:0] != 2'd0) begin
         t = merge({16'd0, m_presc}, wd, {2'b00, be[1:0]});
         m_presc = t[15:0];
         m_ecnt = 1;
      end else if (m_ctrl[0]) m_ecnt++;
`else
      t = 32'd0;
`endif
      if (w && o == 5'h00 && be[0]) m_ctrl = wd[2:0];
      m_count = nc;
   endtask

   task automatic cyc(input logic rst, input logic re, input logic we, input logic [3:0] be,
                      input logic [31:0] a, input logic [31:0] wd, output logic [31:0] rd, output logic irq);
      iRST = rst; iReadEnable = re; iWriteEnable = we; iByteEnable = be; iAddress = a; iWriteData = wd;
      #1;
      rd = oReadData;
      irq = oIRQ;
      check("hit", {31'd0, oHit}, {31'd0, a[31:5] == BASE[31:5]});
      check("rdata", oReadData, re ? m_read(a) : 32'd0);
      check("irq", {31'd0, oIRQ}, {31'd0, m_match & m_ctrl[2]});
      @(posedge clk);
      model_step(rst, we, be, a, wd);
      @(negedge clk);
   endtask

   task automatic wr(input logic [4:0] o, input logic [31:0] d, input logic [3:0] be);
      logic [31:0] x;
      logic y;
      cyc(1'b0, 1'b0, 1'b1, be, BASE + {27'd0, o}, d, x, y);
   endtask

   task automatic rdr(input logic [4:0] o, output logic [31:0] d, output logic irq);
      cyc(1'b0, 1'b1, 1'b0, 4'd0, BASE + {27'd0, o}, $urandom, d, irq);
   endtask

   initial begin
      model_step(1'b1, 1'b0, 4'd0, 32'd0, 32'd0);
      @(negedge clk);
      cyc(1'b1, 1'b0, 1'b0, 4'd0, BASE, 32'd0, r, q);
      for (int i = 0; i < 8; i++) begin
         rdr(5'(4 * i), r, q);
         check("reset_read", r, 32'd0);
         check("reset_irq", {31'd0, q}, 32'd0);
      end
      cyc(1'b0, 1'b1, 1'b0, 4'd0, BASE + 32'h40, 32'd0, r, q);
      check("outside_read", r, 32'd0);
      iAddress = BASE + 32'h40;
      #1 check("outside_hit", {31'd0, oHit}, 32'd0);
      wr(5'h04, 32'h1122_3344, 4'hF);
      wr(5'h04, 32'hAABB_CCDD, 4'b0100);
      rdr(5'h04, r, q);
      check("be_write", r, 32'h11BB_3344);
      wr(5'h04, 32'd0, 4'hF);
      wr(5'h08, 32'd5, 4'hF);
      wr(5'h00, 32'h5, 4'h1);
      for (int i = 0; i < 6; i++) rdr(5'h0C, r, q);
      rdr(5'h04, r, q);
      check("match_count", r, 32'd6);
      check("match_irq", {31'd0, q}, 32'd1);
      wr(5'h0C, 32'd1, 4'h1);
      rdr(5'h0C, r, q);
      check("w1c_status", r, 32'd0);
      check("w1c_irq", {31'd0, q}, 32'd0);
      wr(5'h00, 32'd0, 4'h1);
      wr(5'h04, 32'd0, 4'hF);
      wr(5'h08, 32'd3, 4'hF);
      wr(5'h0C, 32'd1, 4'h1);
      wr(5'h00, 32'h3, 4'h1);
      for (int i = 0; i < 8; i++) begin
         rdr(5'h04, r, q);
         check("autoreload_seq", r, 32'(i % 4));
      end
      rdr(5'h0C, r, q);
      check("autoreload_match", r, 32'd1);
      wr(5'h00, 32'd0, 4'h1);
      wr(5'h04, 32'd2, 4'hF);
      wr(5'h08, 32'd3, 4'hF);
      wr(5'h0C, 32'd1, 4'h1);
      wr(5'h00, 32'h1, 4'h1);
      rdr(5'h04, r, q);
      check("pre_collide", r, 32'd2);
      wr(5'h0C, 32'd1, 4'h1);
      rdr(5'h0C, r, q);
      check("set_beats_clear", r, 32'd1);
      wr(5'h04, 32'h100, 4'hF);
      rdr(5'h04, r, q);
      check("count_write_wins", r, 32'h100);
      rdr(5'h04, r, q);
      check("count_after_write", r, 32'h101);
      for (int i = 0; i < 400; i++) begin
         logic [31:0] a, d;
         logic [2:0] sel;
         sel = 3'($urandom_range(0, 7));
         a = ($urandom_range(0, 7) == 0) ? BASE + 32'(32 * $urandom_range(1, 64))
                                         : BASE + {27'd0, sel, 2'b00} + 32'($urandom_range(0, 3));
         d = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 12)) : $urandom;
         cyc($urandom_range(0, 63) == 0, $urandom_range(0, 9) < 7, $urandom_range(0, 2) == 0,
             4'($urandom), a, d, r, q);
      end
`ifdef TIMER_PRESCALER_EN
      cyc(1'b1, 1'b0, 1'b0, 4'd0, BASE, 32'd0, r, q);
      wr(5'h10, 32'd3, 4'b0011);
      wr(5'h00, 32'h1, 4'h1);
      for (int i = 0; i < 12; i++) begin
         rdr(5'h04, r, q);
         check("presc_count", r, 32'(i / 4));
      end
      cyc(1'b1, 1'b0, 1'b1, 4'hF, BASE + 32'h04, 32'h55, r, q);
      for (int i = 0; i < 5; i++) begin
         rdr(5'(4 * i), r, q);
         check("midrun_reset", r, 32'd0);
      end
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
